// File: rtl/data_memory_if.sv
// Memory-side bus between the cache controller (master) and the backing data memory (slave).
//   read      : read request, held high until busywait falls
//   write     : write request, held high until busywait falls
//   address   : byte address, bits [1:0] ignored
//   writedata : write data, stable while write is high
//   readdata  : registered read result
//   busywait  : high while a request is pending or in progress
interface data_memory_if;
  logic        read;
  logic        write;
  logic [7:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        busywait;

  modport master (
    output read,
    output write,
    output address,
    output writedata,
    input  readdata,
    input  busywait
  );

  modport slave (
    input  read,
    input  write,
    input  address,
    input  writedata,
    output readdata,
    output busywait
  );
endinterface

// File: rtl/data_memory.sv
// Word-organised backing data memory with a fixed multi-cycle access latency.
// Models slow main memory behind the cache: one access at a time, busywait stalls
// the requester for LATENCY+1 cycles, followed by a single DONE cycle.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset; clears state, readdata and all words
//   bus   : data_memory_if slave (read/write/address/writedata in, readdata/busywait out)
module data_memory #(
  parameter int unsigned LATENCY = 5,   // BUSY cycles per access, 1..15
  parameter int unsigned WORDS   = 64   // 32-bit words; index = address[7:2]
) (
  input logic          clock,
  input logic          reset,
  data_memory_if.slave bus
);

  localparam int unsigned IdxW = $clog2(WORDS);
  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       mem_q [WORDS];
  logic              mem_we;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.read || bus.write) begin
          state_d = StBusy;
          cnt_d   = CntW'(LATENCY - 1);
          // Write wins when both are raised together.
          wr_d    = bus.write;
          idx_d   = bus.address[IdxW+1:2];
          wdata_d = bus.writedata;
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          state_d = StDone;
          if (wr_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem_q[idx_q];
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        // Requests still high here are the ones just completed; ignore them.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      for (int i = 0; i < int'(WORDS); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      if (mem_we) begin
        mem_q[idx_q] <= wdata_q;
      end
    end
  end

  // Combinational so the requester stalls in the same cycle it raises a request;
  // gated by reset so it drops immediately when reset asserts.
  assign bus.busywait = reset &&
                        (((state_q == StIdle) && (bus.read || bus.write)) ||
                         (state_q == StBusy));
  assign bus.readdata = rdata_q;

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;
  localparam int unsigned Latency = 5;
  localparam int          ExpBusy = Latency + 1;

  logic clock = 1'b0;
  logic reset;

  data_memory_if mem_if ();

  data_memory #(
    .LATENCY(Latency),
    .WORDS  (64)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (mem_if)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Counts busywait-high cycles from the current cycle; returns at the negedge of the
  // first cycle with busywait low (the DONE cycle).
  task automatic wait_done(output int busy);
    bit done;
    busy = 0;
    done = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clock);
      if (!mem_if.busywait) done = 1'b1;
      else busy++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_done timeout: busywait still 1 after %0d cycles", busy);
    end
  endtask

  task automatic access(input logic rd, input logic wr, input logic [7:0] addr,
                        input logic [31:0] wd, output int busy, output logic [31:0] rdv);
    @(posedge clock);
    #1;
    mem_if.read      = rd;
    mem_if.write     = wr;
    mem_if.address   = addr;
    mem_if.writedata = wd;
    wait_done(busy);
    rdv = mem_if.readdata;
    mem_if.read  = 1'b0;
    mem_if.write = 1'b0;
  endtask

  initial begin
    int          busy;
    logic [31:0] rdv;

    // Writes report readdata unchanged (previous read result).
    vecs[0]  = '{1'b1, 1'b0, 8'h10, 32'h0000_0000, 32'h0000_0000};
    vecs[1]  = '{1'b0, 1'b1, 8'h24, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[2]  = '{1'b1, 1'b0, 8'h24, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 1'b1, 8'h27, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 1'b0, 8'h24, 32'h0000_0000, 32'h1234_5678};
    vecs[5]  = '{1'b1, 1'b0, 8'h28, 32'h0000_0000, 32'h0000_0000};
    vecs[6]  = '{1'b1, 1'b1, 8'h08, 32'hA5A5_A5A5, 32'h0000_0000};
    vecs[7]  = '{1'b1, 1'b0, 8'h08, 32'h0000_0000, 32'hA5A5_A5A5};
    vecs[8]  = '{1'b0, 1'b1, 8'hFF, 32'h0BAD_CAFE, 32'hA5A5_A5A5};
    vecs[9]  = '{1'b1, 1'b0, 8'hFC, 32'h0000_0000, 32'h0BAD_CAFE};
    vecs[10] = '{1'b1, 1'b0, 8'hF8, 32'h0000_0000, 32'h0000_0000};

    mem_if.read      = 1'b1;   // request held during reset must not raise busywait
    mem_if.write     = 1'b0;
    mem_if.address   = 8'h00;
    mem_if.writedata = 32'h0;
    reset            = 1'b0;
    #1;
    check("reset_busywait", 32'(mem_if.busywait), 32'd0);
    check("reset_readdata", mem_if.readdata, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    check("reset_busywait_held", 32'(mem_if.busywait), 32'd0);
    mem_if.read = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 11; i++) begin
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, busy, rdv);
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(ExpBusy));
      check($sformatf("vec%0d_rdata", i), rdv, vecs[i].exp_rdata);
    end

    // Address/data changed mid-BUSY: latched 0x30 / 0x11111111 must be used.
    @(posedge clock);
    #1;
    mem_if.write     = 1'b1;
    mem_if.address   = 8'h30;
    mem_if.writedata = 32'h1111_1111;
    repeat (2) @(posedge clock);
    #1;
    mem_if.address   = 8'h34;
    mem_if.writedata = 32'h2222_2222;
    wait_done(busy);
    check("midop_busy_remaining", 32'(busy), 32'(ExpBusy - 2));
    mem_if.write = 1'b0;
    access(1'b1, 1'b0, 8'h30, 32'h0, busy, rdv);
    check("midop_rd30", rdv, 32'h1111_1111);
    access(1'b1, 1'b0, 8'h34, 32'h0, busy, rdv);
    check("midop_rd34", rdv, 32'h0000_0000);

    // Request held through DONE: re-accepted only in the following IDLE cycle.
    @(posedge clock);
    #1;
    mem_if.read    = 1'b1;
    mem_if.address = 8'h30;
    wait_done(busy);
    check("held_first_busy", 32'(busy), 32'(ExpBusy));
    check("held_first_rdata", mem_if.readdata, 32'h1111_1111);
    mem_if.address = 8'h24;
    @(posedge clock);
    #1;
    check("held_idle_busywait", 32'(mem_if.busywait), 32'd1);
    wait_done(busy);
    check("held_second_busy", 32'(busy), 32'(ExpBusy));
    check("held_second_rdata", mem_if.readdata, 32'h1234_5678);
    mem_if.read = 1'b0;

    // Reset during BUSY cycle 3 of a write: busywait drops at once, write is lost.
    @(posedge clock);
    #1;
    mem_if.write     = 1'b1;
    mem_if.address   = 8'h40;
    mem_if.writedata = 32'hCAFE_F00D;
    repeat (3) @(posedge clock);
    #1;
    check("rst_mid_busy_before", 32'(mem_if.busywait), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_busywait", 32'(mem_if.busywait), 32'd0);
    check("rst_mid_readdata", mem_if.readdata, 32'h0);
    @(negedge clock);
    mem_if.write = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    access(1'b1, 1'b0, 8'h40, 32'h0, busy, rdv);
    check("rst_rd40_busy", 32'(busy), 32'(ExpBusy));
    check("rst_rd40", rdv, 32'h0000_0000);
    access(1'b1, 1'b0, 8'h24, 32'h0, busy, rdv);
    check("rst_rd24_cleared", rdv, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
